// File: rtl/ccff_bitstream_loader.sv
// Bitstream word loader for the eFPGA configuration chain: serializes words LSB-first onto ccff_head.
// Define CCFF_READBACK_VERIFY_EN to build the CRC-checked recirculating readback pass.
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 80,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              verify_ok
);

  localparam int BW = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_sent;
  logic [BW-1:0]     r_cnt;
  logic [WORD_W-1:0] r_buf;
  logic              r_head;
  logic              r_shift_en;
  logic              r_done;

  logic [CNT_W-1:0]  w_remain;
  logic [BW-1:0]     w_take;
  logic              w_last_bit;

  assign word_ready    = (r_state == S_LOAD) && (r_cnt == '0) && (r_sent < CNT_W'(CHAIN_LEN));
  assign ccff_head     = r_head;
  assign ccff_shift_en = r_shift_en;
  assign busy          = (r_state == S_LOAD) || (r_state == S_VERIFY);
  assign done          = r_done;

  // The final word may be partial; only the bits that still fit in the chain are shifted.
  assign w_remain   = CNT_W'(CHAIN_LEN) - r_sent;
  assign w_take     = (32'(w_remain) < WORD_W) ? BW'(w_remain) : BW'(WORD_W);
  assign w_last_bit = (r_sent == CNT_W'(CHAIN_LEN - 1));

`ifdef CCFF_READBACK_VERIFY_EN
  logic [15:0]      r_crc_tx;
  logic [15:0]      r_crc_rx;
  logic [CNT_W-1:0] r_vcnt;
  logic             r_verify_ok;
  logic [15:0]      w_crc_rx_next;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  assign w_crc_rx_next = crc_step(r_crc_rx, ccff_tail);
  assign verify_ok     = r_verify_ok;
`else
  logic w_unused_tail;
  assign w_unused_tail = ccff_tail;
  assign verify_ok     = 1'b0;
`endif

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      r_state    <= S_IDLE;
      r_sent     <= '0;
      r_cnt      <= '0;
      r_buf      <= '0;
      r_head     <= 1'b0;
      r_shift_en <= 1'b0;
      r_done     <= 1'b0;
`ifdef CCFF_READBACK_VERIFY_EN
      r_crc_tx    <= 16'hFFFF;
      r_crc_rx    <= 16'hFFFF;
      r_vcnt      <= '0;
      r_verify_ok <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_shift_en <= 1'b0;
          if (start) begin
            r_state <= S_LOAD;
            r_sent  <= '0;
            r_cnt   <= '0;
            r_head  <= 1'b0;
            r_done  <= 1'b0;
`ifdef CCFF_READBACK_VERIFY_EN
            r_crc_tx    <= 16'hFFFF;
            r_crc_rx    <= 16'hFFFF;
            r_verify_ok <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (r_cnt != '0) begin
            r_head     <= r_buf[0];
            r_shift_en <= 1'b1;
            r_buf      <= r_buf >> 1;
            r_cnt      <= r_cnt - BW'(1);
            r_sent     <= r_sent + CNT_W'(1);
`ifdef CCFF_READBACK_VERIFY_EN
            r_crc_tx <= crc_step(r_crc_tx, r_buf[0]);
            if (w_last_bit) begin
              r_state <= S_VERIFY;
              r_vcnt  <= '0;
            end
`else
            if (w_last_bit) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
`endif
          end else begin
            r_shift_en <= 1'b0;
            if (word_ready && word_valid) begin
              r_buf <= word_data;
              r_cnt <= w_take;
            end
          end
        end
`ifdef CCFF_READBACK_VERIFY_EN
        S_VERIFY: begin
          // Feeding the tail back into the head rotates the chain once over CHAIN_LEN shifts.
          r_head     <= ccff_tail;
          r_shift_en <= 1'b1;
          r_crc_rx   <= w_crc_rx_next;
          r_vcnt     <= r_vcnt + CNT_W'(1);
          if (r_vcnt == CNT_W'(CHAIN_LEN - 1)) begin
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_verify_ok <= (w_crc_rx_next == r_crc_tx);
          end
        end
`endif
        default: begin
          r_state    <= S_IDLE;
          r_shift_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Self-checking bench: 10-bit chain model on the fabric side, randomized words and gaps, CRC reference.
module tb_ccff_bitstream_loader;
  localparam int L = 10;
  localparam int W = 8;
`ifdef CCFF_READBACK_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  logic prog_clk = 1'b0;
  logic prog_reset = 1'b1;
  logic start = 1'b0;
  logic word_valid = 1'b0;
  logic [W-1:0] word_data = '0;
  logic word_ready, ccff_head, ccff_shift_en, busy, done, verify_ok;
  logic ccff_tail;

  int n_cmp = 0;
  int n_fail = 0;

  // Fabric chain model: shifts on the edge following a cycle with shift enable asserted.
  logic [L-1:0] chain = '0;
  int shift_total = 0;
  int flip_at = -1;
  bit head_q[$];

  assign ccff_tail = chain[L-1];

  ccff_bitstream_loader #(.CHAIN_LEN(L), .WORD_W(W)) dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
    .busy(busy), .done(done), .verify_ok(verify_ok)
  );

  always #5 prog_clk = ~prog_clk;

  always @(negedge prog_clk) begin
    if (ccff_shift_en === 1'b1) begin
      logic [L-1:0] c;
      c = {chain[L-2:0], ccff_head};
      shift_total++;
      if (shift_total == flip_at) c[L-1] = ~c[L-1];
      chain = c;
      head_q.push_back(ccff_head);
    end
  end

  function automatic logic [15:0] crc_of(input bit bits[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (bits[i]) begin
      if (c[15] ^ bits[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    bit ok;
    ok = 1'b0;
    word_data  = w;
    word_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (word_ready === 1'b1) ok = 1'b1;
      tick();
    end
    word_valid = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL handshake_timeout word=%h got no word_ready, required within 40 cycles", w);
    end
  endtask

  task automatic run_load(input logic [W-1:0] w0, input logic [W-1:0] w1, input int gap,
                          input int flip_k, input bit poke, input string name,
                          output logic [L-1:0] hv, output logic [L-1:0] cv);
    bit sent_bits[$];
    bit read_bits[$];
    int base, hb, nshift;
    logic [L-1:0] exp_v;
    logic exp_ok;
    for (int i = 0; i < W; i++) sent_bits.push_back(w0[i]);
    for (int i = 0; i < L - W; i++) sent_bits.push_back(w1[i]);
    read_bits = sent_bits;
    if (VER && flip_k > 0) begin
      read_bits[flip_k] = ~read_bits[flip_k];
      flip_at = shift_total + L + flip_k;
    end
    exp_v = '0;
    for (int i = 0; i < L; i++) exp_v[L-1-i] = read_bits[i];
    exp_ok = VER && (crc_of(read_bits) == crc_of(sent_bits));
    base = shift_total;
    hb   = head_q.size();

    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({busy, word_ready, done} !== 3'b110) begin
      n_fail++;
      $display("FAIL %s start_response busy/ready/done=%b required 110", name, {busy, word_ready, done});
    end

    send_word(w0);
    for (int i = 0; i < W; i++) begin
      start = (poke && i == 2);
      tick();
    end
    start = 1'b0;
    for (int g = 0; g < gap; g++) begin
      tick();
      n_cmp++;
      if ({ccff_shift_en, word_ready} !== 2'b01) begin
        n_fail++;
        $display("FAIL %s stall_gap%0d shift_en/ready=%b required 01", name, g, {ccff_shift_en, word_ready});
      end
    end
    send_word(w1);

    for (int i = 0; i < 60 && done !== 1'b1; i++) tick();
    n_cmp++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done_timeout done=%b required 1", name, done);
    end
    tick();

    nshift = shift_total - base;
    hv = '0;
    for (int i = 0; i < L; i++) if (hb + i < head_q.size()) hv[L-1-i] = head_q[hb + i];
    cv = chain;
    flip_at = -1;

    n_cmp++;
    if (nshift != (VER ? 2 * L : L)) begin
      n_fail++;
      $display("FAIL %s shift_count got %0d required %0d", name, nshift, VER ? 2 * L : L);
    end
    n_cmp++;
    if (hv !== exp_v && !(VER && flip_k > 0)) begin
      n_fail++;
      $display("FAIL %s head_sequence got %b required %b", name, hv, exp_v);
    end
    n_cmp++;
    if (cv !== exp_v) begin
      n_fail++;
      $display("FAIL %s chain_content got %b required %b", name, cv, exp_v);
    end
    n_cmp++;
    if ({done, busy, ccff_shift_en, verify_ok} !== {3'b100, exp_ok}) begin
      n_fail++;
      $display("FAIL %s final_status done/busy/shift/vok=%b required %b", name,
               {done, busy, ccff_shift_en, verify_ok}, {3'b100, exp_ok});
    end
    $display("load %s w0=%h w1=%h gap=%0d flip=%0d shifts=%0d chain=%b vok=%b", name, w0, w1,
             gap, flip_k, nshift, cv, verify_ok);
  endtask

  task automatic test_reset();
    prog_reset = 1'b1;
    word_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({word_ready, ccff_head, ccff_shift_en, busy, done, verify_ok} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_outputs got %b required 000000",
                 {word_ready, ccff_head, ccff_shift_en, busy, done, verify_ok});
      end
    end
    prog_reset = 1'b0;
    tick();
    n_cmp++;
    if ({word_ready, ccff_shift_en, busy, done} !== 4'b0) begin
      n_fail++;
      $display("FAIL idle_ignores_valid got %b required 0000", {word_ready, ccff_shift_en, busy, done});
    end
    word_valid = 1'b0;
    $display("reset checked");
  endtask

  task automatic test_basic();
    logic [L-1:0] hv, cv;
    run_load(8'hA5, 8'h03, 0, -1, 1'b0, "basic", hv, cv);
    n_cmp++;
    if (hv !== 10'b1010010111) begin
      n_fail++;
      $display("FAIL basic_head_literal got %b required 1010010111", hv);
    end
    n_cmp++;
    if (cv !== 10'b1010010111) begin
      n_fail++;
      $display("FAIL basic_chain_literal got %b required 1010010111", cv);
    end
  endtask

  task automatic test_backpressure();
    logic [L-1:0] hv, cv;
    run_load(8'hA5, 8'h03, 5, -1, 1'b0, "backpressure", hv, cv);
    n_cmp++;
    if (cv !== 10'b1010010111) begin
      n_fail++;
      $display("FAIL backpressure_chain got %b required 1010010111", cv);
    end
  endtask

  task automatic test_verify();
    logic [L-1:0] hv, cv;
    run_load(8'hA5, 8'h03, 0, -1, 1'b0, "verify_pass", hv, cv);
    run_load(8'hA5, 8'h03, 0, 4, 1'b0, "verify_fail", hv, cv);
  endtask

  task automatic test_done_ignores_valid();
    word_valid = 1'b1;
    word_data  = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({word_ready, ccff_shift_en, done} !== 3'b001) begin
        n_fail++;
        $display("FAIL done_ignores_valid ready/shift/done=%b required 001", {word_ready, ccff_shift_en, done});
      end
    end
    word_valid = 1'b0;
    $display("done-state valid ignore checked");
  endtask

  task automatic test_reset_midload();
    logic [L-1:0] hv, cv;
    int base;
    base = shift_total;
    start = 1'b1;
    tick();
    start = 1'b0;
    send_word(8'h5A);
    for (int i = 0; i < 40 && shift_total - base < 4; i++) tick();
    prog_reset = 1'b1;
    #1;
    n_cmp++;
    if ({word_ready, ccff_head, ccff_shift_en, busy, done, verify_ok} !== 6'b0) begin
      n_fail++;
      $display("FAIL midload_reset got %b required 000000",
               {word_ready, ccff_head, ccff_shift_en, busy, done, verify_ok});
    end
    tick();
    prog_reset = 1'b0;
    tick();
    run_load(W'($urandom), W'($urandom), 0, -1, 1'b0, "after_reset", hv, cv);
  endtask

  task automatic test_back_to_back();
    logic [L-1:0] hv, cv;
    run_load(W'($urandom), W'($urandom), 0, -1, 1'b1, "b2b_a", hv, cv);
    run_load(W'($urandom), W'($urandom), 0, -1, 1'b0, "b2b_b", hv, cv);
  endtask

  task automatic test_random();
    logic [L-1:0] hv, cv;
    int fk;
    for (int n = 0; n < 8; n++) begin
      fk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, L - 1)) : -1;
      run_load(W'($urandom), W'($urandom), int'($urandom_range(0, 4)), fk,
               1'($urandom_range(0, 1)), "random", hv, cv);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    if (VER) test_verify();
    test_done_ignores_valid();
    test_reset_midload();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation exceeded 200000 time units");
    $fatal(1);
  end
endmodule
